// File: rtl/updown_count_sched_if.sv
// Request/grant and count bus between two step-generating requesters and
// the shared up/down counter scheduler.
interface updown_count_sched_if #(
    parameter int WIDTH = 3,
    parameter int LEN_W = 3
);
    logic             req0;
    logic             dir0;
    logic [LEN_W-1:0] len0;
    logic             req1;
    logic             dir1;
    logic [LEN_W-1:0] len1;
    logic             hold;
    logic             gnt0;
    logic             gnt1;
    logic             done0;
    logic             done1;
    logic             busy;
    logic             owner;
    logic [WIDTH-1:0] q;

    modport master (
        output req0, dir0, len0, req1, dir1, len1, hold,
        input  gnt0, gnt1, done0, done1, busy, owner, q
    );

    modport slave (
        input  req0, dir0, len0, req1, dir1, len1, hold,
        output gnt0, gnt1, done0, done1, busy, owner, q
    );
endinterface

// File: rtl/updown_count_sched.sv
// Round-robin arbiter sharing one mod-2^WIDTH up/down counter between two
// requesters; each grant runs a burst of len+1 steps, then releases it.
module updown_count_sched #(
    parameter int WIDTH     = 3,
    parameter int RESET_VAL = 7,
    parameter int LEN_W     = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    updown_count_sched_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);
    localparam logic [WIDTH-1:0] INIT_W = WIDTH'(RESET_VAL);
    localparam logic [LEN_W-1:0] ONE_L  = LEN_W'(1);
    localparam logic [LEN_W-1:0] ZERO_L = LEN_W'(0);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             dir_q, dir_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             done0_q, done0_d;
    logic             done1_q, done1_d;
    logic             busy_q, busy_d;
    logic             win_s;

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        owner_d = owner_q;
        last_d  = last_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        done0_d = 1'b0;
        done1_d = 1'b0;
        busy_d  = busy_q;
        win_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // On a tie the requester that did not own the last burst wins
                if (bus.req0 && bus.req1) begin
                    win_s = ~last_q;
                end else begin
                    win_s = bus.req1;
                end
                if (bus.req0 || bus.req1) begin
                    owner_d = win_s;
                    dir_d   = win_s ? bus.dir1 : bus.dir0;
                    rem_d   = win_s ? bus.len1 : bus.len0;
                    gnt0_d  = ~win_s;
                    gnt1_d  = win_s;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            ST_RUN: begin
                if (!bus.hold) begin
                    count_d = dir_q ? (count_q - ONE_W) : (count_q + ONE_W);
                    if (rem_q == ZERO_L) begin
                        state_d = ST_DONE;
                        done0_d = ~owner_q;
                        done1_d = owner_q;
                    end else begin
                        rem_d = rem_q - ONE_L;
                    end
                end else begin
                    count_d = count_q;
                    rem_d   = rem_q;
                end
            end
            ST_DONE: begin
                last_d  = owner_q;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= INIT_W;
            rem_q   <= ZERO_L;
            dir_q   <= 1'b0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.gnt0  = gnt0_q;
    assign bus.gnt1  = gnt1_q;
    assign bus.done0 = done0_q;
    assign bus.done1 = done1_q;
    assign bus.busy  = busy_q;
    assign bus.owner = owner_q;
    assign bus.q     = count_q;
endmodule

// File: doc/updown_count_sched.md
Name: updown_count_sched

Overview:
- Round-robin scheduler that shares one mod-2^WIDTH up/down count register between two requesters.
- Each grant runs a burst of len+1 count steps in the requested direction, then releases the counter.
- Sits between step-generating control logic and the counter datapath.
- Holds the shared count value internally and exposes it on q.

Parameters:
WIDTH, 3, count register width; count wraps modulo 2^WIDTH
RESET_VAL, 7, value loaded into q on reset (all ones for WIDTH=3)
LEN_W, 3, width of burst-length fields; steps per burst = len+1 (1..2^LEN_W)

Ports:
clock  input  1  single system clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
req0  input  1  requester 0 request; level, held until gnt0
dir0  input  1  requester 0 direction: 0=up, 1=down
len0  input  LEN_W  requester 0 burst length minus one
req1  input  1  requester 1 request
dir1  input  1  requester 1 direction
len1  input  LEN_W  requester 1 burst length minus one
hold  input  1  pauses stepping while high (RUN only)
gnt0  output  1  one-cycle acceptance pulse for requester 0
gnt1  output  1  one-cycle acceptance pulse for requester 1
done0  output  1  one-cycle burst-complete pulse for requester 0
done1  output  1  one-cycle burst-complete pulse for requester 1
busy  output  1  high while a burst is in progress or completing
owner  output  1  index of current/last granted requester
q  output  WIDTH  shared count value

Behaviour:
- Clock and reset: one clock, named clock. Reset is synchronous and active-high, named reset.
- Reset has priority over all other inputs. At the reset edge:
  - q=RESET_VAL, state=IDLE.
  - gnt0, gnt1, done0, done1 and busy go to 0; owner=0.
  - Round-robin pointer is set so requester 0 wins the first tie.
- Reset asserted mid-burst: the burst is aborted. No done pulse. q returns to RESET_VAL.
- All outputs are registered.
- FSM states: IDLE, RUN, DONE.
- IDLE, at a rising edge with any req high:
  - If only one requester is requesting, it wins.
  - If both are requesting, the requester that was not the last owner wins.
  - The winner's dir and len are latched, owner is updated, and remaining=len.
  - State moves to RUN. The matching gnt is high for exactly the next cycle. busy goes to 1.
  - No req high at the edge: stay in IDLE; q holds.
- RUN, at each edge:
  - hold=1: q and remaining are frozen.
  - hold=0: q steps by +1 (dir=0) or -1 (dir=1), modulo 2^WIDTH.
  - Wrap values: 2^WIDTH-1 steps up to 0; 0 steps down to 2^WIDTH-1.
  - hold=0 and remaining==0: this is the final step; state moves to DONE. Otherwise remaining decrements.
  - The first step can occur at the edge that ends the gnt cycle.
  - With hold=0 throughout, burst duration is len+1 cycles in RUN.
- DONE: lasts one cycle.
  - The owner's done pulse is high during this cycle; busy=1.
  - The round-robin pointer is updated to the owner.
  - Next state is IDLE; busy drops in the IDLE cycle.
- req is not sampled in RUN or DONE. A waiting requester is evaluated in the first IDLE cycle.
- Minimum gap between bursts: one IDLE cycle.
- A requester dropping req during RUN does not abort the burst.
- Changes to dir or len after acceptance are ignored.
- gnt0 and gnt1 are never high together. done0 and done1 are never high together.
- Requester protocol: keep req high until gnt is seen; drop req in the gnt cycle unless another burst is wanted.
- q changes only in RUN, or on reset.

Test Plan:
1. reset held 2 cycles then released, no req -> q=7, busy=0, all gnt and done outputs =0, owner=0.
2. After reset, req0=1, dir0=0, len0=2 -> gnt0 pulse for 1 cycle; q steps 0,1,2 on 3 successive edges; done0 pulse in the DONE cycle; busy returns to 0 the cycle after DONE.
3. req0 and req1 both held from reset -> gnt0 first; after done0 and one IDLE cycle, gnt1. With both still requesting, the next grant is gnt0 (alternation).
4. Down wrap: from q=1, req1=1, dir1=1, len1=3 -> q = 0,7,6,5; then done1 pulse; owner=1.
5. hold=1 for 2 cycles mid-burst (len=4, up from 0) -> q frozen 2 cycles; final q=5; done delayed by exactly 2 cycles.
6. reset pulsed while in RUN at q=3 -> next edge q=7, busy=0, no done pulse; a new req afterwards is granted normally.
